// File: rtl/div_result_bcd_if.sv
// Handshake and payload bundle between the signed divider, the BCD converter
// and the readout logic.
interface div_result_bcd_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Quo;
    logic [WIDTH-1:0] Rem;
    logic             out_valid;
    logic             out_ready;
    logic             quo_sign;
    logic [BCD_W-1:0] quo_bcd;
    logic             rem_sign;
    logic [BCD_W-1:0] rem_bcd;
    logic             busy;

    modport master (
        output in_valid, Quo, Rem, out_ready,
        input  in_ready, out_valid, quo_sign, quo_bcd, rem_sign, rem_bcd, busy
    );

    modport slave (
        input  in_valid, Quo, Rem, out_ready,
        output in_ready, out_valid, quo_sign, quo_bcd, rem_sign, rem_bcd, busy
    );
endinterface

// File: rtl/div_result_bcd.sv
// Converts a signed quotient/remainder pair to sign-magnitude packed BCD with
// two parallel double-dabble engines, one bit per clock.
module div_result_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    div_result_bcd_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Decimal digit count of 2^WIDTH, i.e. ceil(WIDTH*log10(2)).
    function automatic int unsigned dec_digits_pow2(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = 64'd1 << w;
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    if (DIGITS < dec_digits_pow2(WIDTH)) begin : g_digits_check
        $error("div_result_bcd: DIGITS too small for WIDTH");
    end

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_mag_q, quo_mag_d, rem_mag_q, rem_mag_d;
    logic [BCD_W-1:0] quo_acc_q, quo_acc_d, rem_acc_q, rem_acc_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             quo_sign_q, quo_sign_d, rem_sign_q, rem_sign_d;
    logic [BCD_W-1:0] quo_bcd_q, quo_bcd_d, rem_bcd_q, rem_bcd_d;
    logic [BCD_W-1:0] quo_adj, rem_adj;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_mag_q   <= '0;
            rem_mag_q   <= '0;
            quo_acc_q   <= '0;
            rem_acc_q   <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            quo_sign_q  <= 1'b0;
            rem_sign_q  <= 1'b0;
            quo_bcd_q   <= '0;
            rem_bcd_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_mag_q   <= quo_mag_d;
            rem_mag_q   <= rem_mag_d;
            quo_acc_q   <= quo_acc_d;
            rem_acc_q   <= rem_acc_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            quo_sign_q  <= quo_sign_d;
            rem_sign_q  <= rem_sign_d;
            quo_bcd_q   <= quo_bcd_d;
            rem_bcd_q   <= rem_bcd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_mag_d   = quo_mag_q;
        rem_mag_d   = rem_mag_q;
        quo_acc_d   = quo_acc_q;
        rem_acc_d   = rem_acc_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        out_valid_d = out_valid_q;
        quo_sign_d  = quo_sign_q;
        rem_sign_d  = rem_sign_q;
        quo_bcd_d   = quo_bcd_q;
        rem_bcd_d   = rem_bcd_q;
        quo_adj     = add3(quo_acc_q);
        rem_adj     = add3(rem_acc_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = SHIFT;
                    quo_neg_d = bus.Quo[WIDTH-1];
                    rem_neg_d = bus.Rem[WIDTH-1];
                    // Unsigned magnitude: -2^(WIDTH-1) maps onto itself.
                    quo_mag_d = bus.Quo[WIDTH-1] ? WIDTH'(-bus.Quo) : bus.Quo;
                    rem_mag_d = bus.Rem[WIDTH-1] ? WIDTH'(-bus.Rem) : bus.Rem;
                    quo_acc_d = '0;
                    rem_acc_d = '0;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                quo_acc_d = {quo_adj[BCD_W-2:0], quo_mag_q[WIDTH-1]};
                rem_acc_d = {rem_adj[BCD_W-2:0], rem_mag_q[WIDTH-1]};
                quo_mag_d = {quo_mag_q[WIDTH-2:0], 1'b0};
                rem_mag_d = {rem_mag_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quo_sign_d  = quo_neg_q;
                    rem_sign_d  = rem_neg_q;
                    quo_bcd_d   = quo_acc_d;
                    rem_bcd_d   = rem_acc_d;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.quo_sign  = quo_sign_q;
    assign bus.rem_sign  = rem_sign_q;
    assign bus.quo_bcd   = quo_bcd_q;
    assign bus.rem_bcd   = rem_bcd_q;
endmodule
